// File: rtl/matrix_addsub_engine.sv
// ---------------------------------------------------------------------------
// adder
//   Single-precision IEEE-754 adder core with a load / ready / ack handshake.
//   Round-to-nearest-even, subnormals supported, NaN/Inf propagated.
//   Ports: clk, reset (sync, active-high), load (1-cycle operand strobe),
//          Number1/Number2 (operands), result_ack (1-cycle consume strobe),
//          Result (held while result_ready), result_ready.
//
// matrix_addsub_engine
//   ROWSxCOLS matrix add/subtract (C = A + B or C = A - B) that streams
//   elements through LANES adder cores, LANES elements per batch.
//   Ports: input_Clk, input_Reset (sync, active-high), input_Start,
//          input_Mode (0 add, 1 subtract), input_A/input_B (row-major, element
//          k at bits [32k+31:32k]), input_C_Ack, output_C (same packing),
//          output_Stable (result complete and held), output_Busy.
// ---------------------------------------------------------------------------
module adder (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] Number1,
  input  logic [31:0] Number2,
  input  logic        result_ack,
  output logic [31:0] Result,
  output logic        result_ready
);
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic        busy_q, busy_d, ready_q, ready_d;
  logic [31:0] fp_sum;
  logic        a_big, s_l, s_s, spec_a, spec_b, nan_in, sticky;
  logic [7:0]  e_l, e_s, diff;
  logic [23:0] m_l, m_s;
  logic [26:0] sh;
  logic [27:0] sum, norm;
  logic [9:0]  exp_w, lz, shift, exp_f;
  logic [24:0] rnd;

  // Larger magnitude goes to the "l" side so the mantissa subtraction never
  // goes negative; 3 extra bits carry guard/round/sticky through alignment.
  always_comb begin
    nan_in = 1'b0;
    shift  = '0;
    spec_a = &a_q[30:23];
    spec_b = &b_q[30:23];
    a_big  = a_q[30:0] >= b_q[30:0];
    s_l    = a_big ? a_q[31] : b_q[31];
    s_s    = a_big ? b_q[31] : a_q[31];
    e_l    = a_big ? a_q[30:23] : b_q[30:23];
    e_s    = a_big ? b_q[30:23] : a_q[30:23];
    m_l    = {|e_l, (a_big ? a_q[22:0] : b_q[22:0])};
    m_s    = {|e_s, (a_big ? b_q[22:0] : a_q[22:0])};
    // Subnormals share exponent 1 with a hidden bit of 0.
    if (e_l == 8'd0) e_l = 8'd1;
    if (e_s == 8'd0) e_s = 8'd1;
    diff = e_l - e_s;
    if (diff > 8'd26) begin
      sh     = '0;
      sticky = |m_s;
    end else begin
      sh     = {m_s, 3'b000} >> diff;
      sticky = |({m_s, 3'b000} & ~(27'h7FFFFFF << diff));
    end
    if (s_l == s_s) sum = {1'b0, m_l, 3'b000} + {1'b0, sh[26:1], sh[0] | sticky};
    else            sum = {1'b0, m_l, 3'b000} - {1'b0, sh[26:1], sh[0] | sticky};
    lz = 10'd27;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 10'(26 - i);
    exp_w = {2'b00, e_l};
    if (sum[27]) begin
      norm  = {1'b0, sum[27:2], |sum[1:0]};
      exp_w = exp_w + 10'd1;
    end else begin
      // Normalisation stops at exponent 1, leaving a subnormal.
      shift = (lz < exp_w) ? lz : exp_w - 10'd1;
      norm  = sum << shift;
      exp_w = exp_w - shift;
    end
    rnd = {1'b0, norm[26:3]} + 25'(norm[2] & ((|norm[1:0]) | norm[3]));
    if (rnd[24])      exp_f = exp_w + 10'd1;
    else if (rnd[23]) exp_f = exp_w;
    else              exp_f = '0;
    if (spec_a || spec_b) begin
      nan_in = (spec_a && |a_q[22:0]) || (spec_b && |b_q[22:0]) ||
               (spec_a && spec_b && (a_q[31] != b_q[31]));
      fp_sum = nan_in ? 32'h7FC00000 : (spec_a ? a_q : b_q);
    end else if (sum == 28'd0) begin
      fp_sum = {s_l & s_s, 31'd0};
    end else if (exp_f >= 10'd255) begin
      fp_sum = {s_l, 8'hFF, 23'd0};
    end else begin
      fp_sum = {s_l, exp_f[7:0], (rnd[24] ? 23'd0 : rnd[22:0])};
    end
  end

  // Handshake: capture on load, publish one cycle later, hold until ack.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    if (busy_q) begin
      result_d = fp_sum;
      ready_d  = 1'b1;
      busy_d   = 1'b0;
    end else if (ready_q) begin
      if (result_ack) ready_d = 1'b0;
    end else if (load) begin
      a_d    = Number1;
      b_d    = Number2;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign Result       = result_q;
  assign result_ready = ready_q;
endmodule

module matrix_addsub_engine #(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int LANES = 2
) (
  input  logic                     input_Clk,
  input  logic                     input_Reset,
  input  logic                     input_Start,
  input  logic                     input_Mode,
  input  logic [32*ROWS*COLS-1:0]  input_A,
  input  logic [32*ROWS*COLS-1:0]  input_B,
  input  logic                     input_C_Ack,
  output logic [32*ROWS*COLS-1:0]  output_C,
  output logic                     output_Stable,
  output logic                     output_Busy
);
  localparam int N  = ROWS * COLS;
  localparam int NB = N / LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  if (N % LANES != 0) begin : gen_lane_check
    $error("LANES must divide ROWS*COLS");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [32*N-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [BW-1:0]    batch_q, batch_d;
  logic             busy_q, busy_d, stable_q, stable_d;
  logic             lane_load, lane_ack;
  logic [LANES-1:0] lane_ready;
  logic [31:0]      lane_n1 [LANES];
  logic [31:0]      lane_n2 [LANES];
  logic [31:0]      lane_res [LANES];

  // Lane i works on element batch*LANES+i. A load is held back while any
  // lane still shows ready, so a stale result can never satisfy WAIT.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_n1[i] = a_q[(int'(batch_q) * LANES + i) * 32 +: 32];
      lane_n2[i] = b_q[(int'(batch_q) * LANES + i) * 32 +: 32];
    end
    lane_load = (state_q == S_ISSUE) && !(|lane_ready);
    lane_ack  = (state_q == S_ACK);
  end

  for (genvar g = 0; g < LANES; g++) begin : gen_lane
    adder u_adder (
      .clk          (input_Clk),
      .reset        (input_Reset),
      .load         (lane_load),
      .Number1      (lane_n1[g]),
      .Number2      (lane_n2[g]),
      .result_ack   (lane_ack),
      .Result       (lane_res[g]),
      .result_ready (lane_ready[g])
    );
  end

  // Sequencer: subtraction is folded into capture by negating B's sign bits.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    batch_d  = batch_q;
    busy_d   = busy_q;
    stable_d = stable_q;
    unique case (state_q)
      S_IDLE: if (input_Start) begin
        a_d = input_A;
        b_d = input_B;
        for (int k = 0; k < N; k++) b_d[32*k+31] = input_B[32*k+31] ^ input_Mode;
        batch_d = '0;
        busy_d  = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: if (lane_load) state_d = S_WAIT;
      S_WAIT: if (&lane_ready) begin
        for (int i = 0; i < LANES; i++)
          c_d[(int'(batch_q) * LANES + i) * 32 +: 32] = lane_res[i];
        state_d = S_ACK;
      end
      S_ACK: begin
        if (batch_q == BW'(NB - 1)) begin
          stable_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          batch_d = batch_q + BW'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: if (input_C_Ack) begin
        stable_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge input_Clk) begin
    if (input_Reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      batch_q  <= '0;
      busy_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      batch_q  <= batch_d;
      busy_q   <= busy_d;
      stable_q <= stable_d;
    end
  end

  assign output_C      = c_q;
  assign output_Stable = stable_q;
  assign output_Busy   = busy_q;
endmodule

// File: tb/tb_matrix_addsub_engine.sv
// ---------------------------------------------------------------------------
// tb_matrix_addsub_engine
//   Self-checking bench for matrix_addsub_engine. Two instances: the default
//   2x2 / 2-lane engine and a 3x2 / 3-lane engine. Expected matrices come
//   from integer arithmetic on values n/8, converted to single precision.
// ---------------------------------------------------------------------------
module tb_matrix_addsub_engine;
  logic         clk = 1'b0;
  logic         reset;
  logic         start1, mode1, ack1, start2, mode2, ack2;
  logic [127:0] a1, b1, c1;
  logic [191:0] a2, b2, c2;
  logic         stable1, busy1, stable2, busy2;
  int           checkCount = 0;
  int           errorCount = 0;

  matrix_addsub_engine dut1 (
    .input_Clk(clk), .input_Reset(reset), .input_Start(start1), .input_Mode(mode1),
    .input_A(a1), .input_B(b1), .input_C_Ack(ack1),
    .output_C(c1), .output_Stable(stable1), .output_Busy(busy1)
  );

  matrix_addsub_engine #(.ROWS(3), .COLS(2), .LANES(3)) dut2 (
    .input_Clk(clk), .input_Reset(reset), .input_Start(start2), .input_Mode(mode2),
    .input_A(a2), .input_B(b2), .input_C_Ack(ack2),
    .output_C(c2), .output_Stable(stable2), .output_Busy(busy2)
  );

  always #5 clk = ~clk;

  // Exact single-precision encoding of n/8 for |n| < 2^23.
  function automatic logic [31:0] floatOf8ths(input int n);
    logic [31:0] mag;
    logic [31:0] bits;
    int p;
    if (n == 0) return 32'd0;
    mag = (n < 0) ? 32'(-n) : 32'(n);
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    bits[31]    = (n < 0);
    bits[30:23] = 8'(p - 3 + 127);
    bits[22:0]  = 23'(mag << (23 - p));
    return bits;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [191:0] a, input logic [191:0] b, input logic mode);
    @(negedge clk);
    if (which == 1) begin start1 = 1'b1; a1 = a[127:0]; b1 = b[127:0]; mode1 = mode; end
    else            begin start2 = 1'b1; a2 = a; b2 = b; mode2 = mode; end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Waits (bounded) for Stable, counting load pulses seen along the way.
  task automatic waitStable(input int which, input string tag, output int loads);
    int n = 0;
    loads = 0;
    while (((which == 1) ? !stable1 : !stable2) && n < 200) begin
      if (which == 1 ? dut1.lane_load : dut2.lane_load) loads++;
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_stable"}, {31'd0, (which == 1) ? stable1 : stable2}, 32'd1);
  endtask

  task automatic checkMatrix(input int which, input string tag, input logic [191:0] expected);
    int cnt = (which == 1) ? 4 : 6;
    for (int k = 0; k < cnt; k++)
      checkOutput($sformatf("%s_c%0d", tag, k),
                  (which == 1) ? c1[32*k +: 32] : c2[32*k +: 32], expected[32*k +: 32]);
  endtask

  task automatic ackOp(input int which, input string tag);
    if (which == 1) ack1 = 1'b1; else ack2 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    ack2 = 1'b0;
    checkOutput({tag, "_ack_stable"}, {31'd0, (which == 1) ? stable1 : stable2}, 32'd0);
    checkOutput({tag, "_ack_busy"}, {31'd0, (which == 1) ? busy1 : busy2}, 32'd0);
  endtask

  task automatic runRandom(input int which, input int idx);
    logic [191:0] a, b, e;
    logic mode;
    int aN, bN, loads;
    int cnt = (which == 1) ? 4 : 6;
    a = '0; b = '0; e = '0;
    mode = 1'($urandom_range(0, 1));
    for (int k = 0; k < cnt; k++) begin
      aN = int'($urandom_range(0, 8000)) - 4000;
      bN = int'($urandom_range(0, 8000)) - 4000;
      a[32*k +: 32] = floatOf8ths(aN);
      b[32*k +: 32] = floatOf8ths(bN);
      e[32*k +: 32] = floatOf8ths(aN + (mode ? -bN : bN));
    end
    applyStimulus(which, a, b, mode);
    waitStable(which, $sformatf("rnd%0d_%0d", which, idx), loads);
    checkMatrix(which, $sformatf("rnd%0d_%0d", which, idx), e);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    ackOp(which, $sformatf("rnd%0d_%0d", which, idx));
  endtask

  initial begin
    logic [191:0] ones, twos, threes, negOnes, zeros, fives, ramp, half, rampExp;
    int loads, n;
    start1 = 0; mode1 = 0; ack1 = 0; a1 = '0; b1 = '0;
    start2 = 0; mode2 = 0; ack2 = 0; a2 = '0; b2 = '0;
    ones = '0; twos = '0; threes = '0; negOnes = '0; zeros = '0; fives = '0;
    ramp = '0; half = '0; rampExp = '0;
    for (int k = 0; k < 6; k++) begin
      ones[32*k +: 32]    = 32'h3F800000;
      twos[32*k +: 32]    = 32'h40000000;
      threes[32*k +: 32]  = 32'h40400000;
      negOnes[32*k +: 32] = 32'hBF800000;
      fives[32*k +: 32]   = 32'h40A00000;
      ramp[32*k +: 32]    = floatOf8ths(8 * k);
      half[32*k +: 32]    = floatOf8ths(4);
      rampExp[32*k +: 32] = floatOf8ths(8 * k + 4);
    end

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkMatrix(1, "reset1", zeros);
    checkOutput("reset1_stable", {31'd0, stable1}, 32'd0);
    checkOutput("reset1_busy", {31'd0, busy1}, 32'd0);
    checkMatrix(2, "reset2", zeros);
    checkOutput("reset2_busy", {31'd0, busy2}, 32'd0);

    $display("[TB] add 1.0 + 2.0");
    applyStimulus(1, ones, twos, 1'b0);
    checkOutput("add_busy", {31'd0, busy1}, 32'd1);
    waitStable(1, "add", loads);
    checkOutput("add_loads", 32'(loads), 32'd2);
    checkMatrix(1, "add", threes);
    ackOp(1, "add");

    $display("[TB] subtract");
    applyStimulus(1, ones, twos, 1'b1);
    waitStable(1, "sub", loads);
    checkMatrix(1, "sub", negOnes);
    ackOp(1, "sub");
    applyStimulus(1, twos, twos, 1'b1);
    waitStable(1, "subeq", loads);
    checkMatrix(1, "subeq", zeros);
    ackOp(1, "subeq");

    $display("[TB] 3x2 with 3 lanes");
    applyStimulus(2, ramp, half, 1'b0);
    waitStable(2, "ramp", loads);
    checkOutput("ramp_loads", 32'(loads), 32'd2);
    checkMatrix(2, "ramp", rampExp);
    checkOutput("ramp_c5_literal", c2[191:160], 32'h40B00000);
    ackOp(2, "ramp");

    $display("[TB] start while busy is ignored");
    applyStimulus(1, ones, twos, 1'b0);
    @(negedge clk);
    start1 = 1'b1; a1 = fives[127:0]; b1 = fives[127:0]; mode1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("ignore_busy", {31'd0, busy1}, 32'd1);
    waitStable(1, "ignore", loads);
    checkMatrix(1, "ignore", threes);

    $display("[TB] hold without ack");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_c_%0d", i), {31'd0, c1 == threes[127:0]}, 32'd1);
      checkOutput($sformatf("hold_stable_%0d", i), {31'd0, stable1}, 32'd1);
    end
    ack1 = 1'b1; start1 = 1'b1; a1 = fives[127:0]; b1 = ones[127:0]; mode1 = 1'b0;
    @(negedge clk);
    ack1 = 1'b0; start1 = 1'b0;
    checkOutput("ackstart_stable", {31'd0, stable1}, 32'd0);
    checkOutput("ackstart_busy", {31'd0, busy1}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("ackstart_idle_busy", {31'd0, busy1}, 32'd0);
    checkMatrix(1, "ackstart_keep", threes);

    $display("[TB] reset during second batch");
    applyStimulus(1, twos, twos, 1'b0);
    n = 0;
    while (!(dut1.lane_load && dut1.batch_q == 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midreset_reach", {31'd0, dut1.lane_load}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkMatrix(1, "midreset", zeros);
    checkOutput("midreset_stable", {31'd0, stable1}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy1}, 32'd0);
    applyStimulus(1, twos, ones, 1'b1);
    waitStable(1, "postreset", loads);
    checkMatrix(1, "postreset", ones);
    ackOp(1, "postreset");

    $display("[TB] random operands");
    for (int i = 0; i < 10; i++) runRandom(1, i);
    for (int i = 0; i < 4; i++) runRandom(2, i);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
